// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and window/tap to pixel index mapping for the
// sequential 4x4 * 3x3 convolution reader.
package conv_pkg;

  localparam int IN_DIM  = 4;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 2;
  localparam int N_TAPS  = 9;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // pos[1]/pos[0] are the window row/col origin; tr/tc walk the 3x3 taps.
  function automatic logic [3:0] pix_index(input logic [1:0] pos,
                                           input logic [1:0] tr,
                                           input logic [1:0] tc);
    int row;
    int col;
    row = int'(pos[1]) + int'(tr);
    col = int'(pos[0]) + int'(tc);
    return 4'(row * IN_DIM + col);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Single unsigned multiply-accumulate: combinational product, registered accumulator.
// One add per enabled cycle; clear has priority over enable; no backpressure.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Snapshots the 4x4 input / 3x3 filter bank on start and emits the four 3x3 window sums.
// First result 10 cycles after start, then one per 11 cycles; results held under out_ready=0.
module conv_window_reader #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int ACC_W  = conv_pkg::ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*DATA_W-1:0] input_flat,
  input  logic [9*DATA_W-1:0]  filter_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [1:0]           out_idx,
  output logic                 busy,
  output logic                 done
);

  import conv_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] pix [IN_DIM*IN_DIM];
  logic [DATA_W-1:0] flt [N_TAPS];
  logic [1:0]        pos;
  logic [1:0]        tr;
  logic [1:0]        tc;
  logic [3:0]        tap;
  logic              prime;
  logic              accept;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;

  assign accept  = (state == OUT) && out_ready;
  assign mac_clr = ((state == IDLE) && start) || accept;
  assign mac_en  = (state == MAC) && !prime;
  assign mac_a   = pix[pix_index(pos, tr, tc)];
  assign mac_b   = flt[tap];
  assign out_idx = pos;

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (mac_b),
    .acc (out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pos       <= '0;
      tr        <= '0;
      tc        <= '0;
      tap       <= '0;
      prime     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < IN_DIM*IN_DIM; i++) pix[i] <= '0;
      for (int k = 0; k < N_TAPS; k++) flt[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < IN_DIM*IN_DIM; i++) pix[i] <= input_flat[i*DATA_W +: DATA_W];
            for (int k = 0; k < N_TAPS; k++) flt[k] <= filter_flat[k*DATA_W +: DATA_W];
            pos   <= '0;
            tr    <= '0;
            tc    <= '0;
            tap   <= '0;
            prime <= 1'b0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          // After an accept the first MAC cycle is a bubble, giving an 11-cycle window period.
          if (prime) begin
            prime <= 1'b0;
          end else begin
            tap <= tap + 4'd1;
            if (tc == 2'(K_DIM-1)) begin
              tc <= '0;
              tr <= tr + 2'd1;
            end else begin
              tc <= tc + 2'd1;
            end
            if (tap == 4'(N_TAPS-1)) begin
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pos == 2'(OUT_DIM*OUT_DIM-1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              pos   <= pos + 2'd1;
              tr    <= '0;
              tc    <= '0;
              tap   <= '0;
              prime <= 1'b1;
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
